// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : Packs a one-hot instruction select plus operand fields into
//                a 32-bit MIPS word and streams it out through a 2-entry
//                buffer tagged with an auto-incrementing word address.
//                Optional macro ENC_FIELD_CHECK_EN rejects nonzero ignored
//                fields as illegal.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef CODE_NUM
`define CODE_NUM 32
`endif

module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [`CODE_NUM:0]  code,
    input  logic [4:0]          rsc,
    input  logic [4:0]          rtc,
    input  logic [4:0]          rdc,
    input  logic [4:0]          sa,
    input  logic [15:0]         immed,
    input  logic [25:0]         j_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         instr_out,
    output logic [ADDR_W-1:0]   out_addr,
    input  logic                load_base,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                err_illegal,
    input  logic                clr_err,
    output logic [15:0]         word_cnt
);

    // Code bit positions (one-hot select index)
    localparam logic [5:0] C_ADD   = 6'd0,  C_ADDU  = 6'd1,  C_SUB   = 6'd2,
                           C_SUBU  = 6'd3,  C_AND   = 6'd4,  C_OR    = 6'd5,
                           C_XOR   = 6'd6,  C_NOR   = 6'd7,  C_SLT   = 6'd8,
                           C_SLTU  = 6'd9,  C_SLLV  = 6'd10, C_SRLV  = 6'd11,
                           C_SRAV  = 6'd12, C_SLL   = 6'd13, C_SRL   = 6'd14,
                           C_SRA   = 6'd15, C_JR    = 6'd16, C_BREAK = 6'd17,
                           C_ADDI  = 6'd18, C_ADDIU = 6'd19, C_ANDI  = 6'd20,
                           C_ORI   = 6'd21, C_XORI  = 6'd22, C_LW    = 6'd23,
                           C_SW    = 6'd24, C_BEQ   = 6'd25, C_BNE   = 6'd26,
                           C_SLTI  = 6'd27, C_SLTIU = 6'd28, C_LUI   = 6'd29,
                           C_J     = 6'd30, C_JAL   = 6'd31, C_MUL   = 6'd32;

    localparam logic [2:0] F_RALU  = 3'd0, F_SHIFT = 3'd1, F_JR   = 3'd2,
                           F_BRK   = 3'd3, F_ITYPE = 3'd4, F_LUI  = 3'd5,
                           F_JUMP  = 3'd6, F_MUL   = 3'd7;

    logic [5:0]         w_idx;
    logic               w_onehot;
    logic               w_known;
    logic [2:0]         w_fmt;
    logic [5:0]         w_func;
    logic [5:0]         w_op;
    logic [31:0]        w_word;
    logic               w_legal;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    logic [31:0]        r_mem_q [0:1];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q,  count_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic [15:0]        cnt_q,    cnt_d;
    logic               err_q,    err_d;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i <= `CODE_NUM; i++) begin
            if (code[i]) w_idx = 6'(i);
        end
    end

    assign w_onehot = (code != '0) && ((code & (code - 1'b1)) == '0);

    always_comb begin
        w_fmt   = F_BRK;
        w_func  = 6'h00;
        w_op    = 6'h00;
        w_known = 1'b1;
        case (w_idx)
            C_ADD:   begin w_fmt = F_RALU;  w_func = 6'h20; end
            C_ADDU:  begin w_fmt = F_RALU;  w_func = 6'h21; end
            C_SUB:   begin w_fmt = F_RALU;  w_func = 6'h22; end
            C_SUBU:  begin w_fmt = F_RALU;  w_func = 6'h23; end
            C_AND:   begin w_fmt = F_RALU;  w_func = 6'h24; end
            C_OR:    begin w_fmt = F_RALU;  w_func = 6'h25; end
            C_XOR:   begin w_fmt = F_RALU;  w_func = 6'h26; end
            C_NOR:   begin w_fmt = F_RALU;  w_func = 6'h27; end
            C_SLT:   begin w_fmt = F_RALU;  w_func = 6'h2A; end
            C_SLTU:  begin w_fmt = F_RALU;  w_func = 6'h2B; end
            C_SLLV:  begin w_fmt = F_RALU;  w_func = 6'h04; end
            C_SRLV:  begin w_fmt = F_RALU;  w_func = 6'h06; end
            C_SRAV:  begin w_fmt = F_RALU;  w_func = 6'h07; end
            C_SLL:   begin w_fmt = F_SHIFT; w_func = 6'h00; end
            C_SRL:   begin w_fmt = F_SHIFT; w_func = 6'h02; end
            C_SRA:   begin w_fmt = F_SHIFT; w_func = 6'h03; end
            C_JR:    w_fmt = F_JR;
            C_BREAK: w_fmt = F_BRK;
            C_ADDI:  begin w_fmt = F_ITYPE; w_op = 6'h08; end
            C_ADDIU: begin w_fmt = F_ITYPE; w_op = 6'h09; end
            C_ANDI:  begin w_fmt = F_ITYPE; w_op = 6'h0C; end
            C_ORI:   begin w_fmt = F_ITYPE; w_op = 6'h0D; end
            C_XORI:  begin w_fmt = F_ITYPE; w_op = 6'h0E; end
            C_LW:    begin w_fmt = F_ITYPE; w_op = 6'h23; end
            C_SW:    begin w_fmt = F_ITYPE; w_op = 6'h2B; end
            C_BEQ:   begin w_fmt = F_ITYPE; w_op = 6'h04; end
            C_BNE:   begin w_fmt = F_ITYPE; w_op = 6'h05; end
            C_SLTI:  begin w_fmt = F_ITYPE; w_op = 6'h0A; end
            C_SLTIU: begin w_fmt = F_ITYPE; w_op = 6'h0B; end
            C_LUI:   w_fmt = F_LUI;
            C_J:     begin w_fmt = F_JUMP;  w_op = 6'h02; end
            C_JAL:   begin w_fmt = F_JUMP;  w_op = 6'h03; end
            C_MUL:   w_fmt = F_MUL;
            default: w_known = 1'b0;
        endcase
    end

    // Fields a format does not use never reach the word.
    always_comb begin
        w_word = 32'h0;
        case (w_fmt)
            F_RALU:  w_word = {6'h00, rsc, rtc, rdc, 5'b0, w_func};
            F_SHIFT: w_word = {6'h00, 5'b0, rtc, rdc, sa, w_func};
            F_JR:    w_word = {6'h00, rsc, 15'b0, 6'h08};
            F_BRK:   w_word = {6'h00, 20'b0, 6'h0D};
            F_ITYPE: w_word = {w_op, rsc, rtc, immed};
            F_LUI:   w_word = {6'h0F, 5'b0, rtc, immed};
            F_JUMP:  w_word = {w_op, j_addr};
            F_MUL:   w_word = {6'h1C, rsc, rtc, rdc, 5'b0, 6'h02};
            default: w_word = 32'h0;
        endcase
    end

`ifdef ENC_FIELD_CHECK_EN
    // Per-format mask of consumed fields, ordered {rs, rt, rd, sa, immed, j_addr}
    logic [5:0] w_used;
    logic [5:0] w_nz;
    logic       w_field_bad;

    always_comb begin
        w_used = 6'b000000;
        case (w_fmt)
            F_RALU:  w_used = 6'b111000;
            F_SHIFT: w_used = 6'b011100;
            F_JR:    w_used = 6'b100000;
            F_BRK:   w_used = 6'b000000;
            F_ITYPE: w_used = 6'b110010;
            F_LUI:   w_used = 6'b010010;
            F_JUMP:  w_used = 6'b000001;
            F_MUL:   w_used = 6'b111000;
            default: w_used = 6'b000000;
        endcase
    end

    assign w_nz        = {|rsc, |rtc, |rdc, |sa, |immed, |j_addr};
    assign w_field_bad = |(w_nz & ~w_used);
    assign w_legal     = w_onehot && w_known && !w_field_bad;
`else
    assign w_legal     = w_onehot && w_known;
`endif

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_legal;
    assign w_pop     = out_valid && out_ready;

    assign instr_out   = out_valid ? r_mem_q[rd_ptr_q] : 32'h0;
    assign out_addr    = addr_q;
    assign err_illegal = err_q;
    assign word_cnt    = cnt_q;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        addr_d = addr_q;
        if (load_base)  addr_d = base_addr;
        else if (w_pop) addr_d = addr_q + 1'b1;

        cnt_d = cnt_q;
        if (w_pop && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;

        // A new illegal accept outranks a simultaneous clear.
        err_d = err_q;
        if (w_accept && !w_legal) err_d = 1'b1;
        else if (clr_err)         err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_q[0] <= 32'h0;
            r_mem_q[1] <= 32'h0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            addr_q     <= '0;
            cnt_q      <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_q[wr_ptr_q] <= w_word;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (w_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

`default_nettype wire
